// File: rtl/pipe_sb_pkg.sv
// Shared constants and helpers for the decode-stage hazard scoreboard.
// Default parameter values, bypass-select encodings and the saturating decrement.
package pipe_sb_pkg;

  localparam int NREG_DEF    = 32;
  localparam int AW_DEF      = 5;
  localparam int LAT_W_DEF   = 3;
  localparam int MAX_LAT_DEF = 7;

  localparam logic FWD_REG = 1'b0;
  localparam logic FWD_BYP = 1'b1;

  // Counter step toward zero; a zero counter stays at zero.
  function automatic logic [LAT_W_DEF-1:0] sat_dec(input logic [LAT_W_DEF-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

endpackage

// File: rtl/pipe_sb_if.sv
// Decode-stage <-> scoreboard signal bundle.
// Handshake: D_Valid offers an instruction, ~Stall accepts it, Issue marks the cycle it is
// consumed; Flush cancels the offer and the instruction issued the cycle before.
interface pipe_sb_if #(
  parameter int NREG  = pipe_sb_pkg::NREG_DEF,
  parameter int AW    = pipe_sb_pkg::AW_DEF,
  parameter int LAT_W = pipe_sb_pkg::LAT_W_DEF
);
  logic             D_Valid;
  logic [AW-1:0]    D_Rs;
  logic [AW-1:0]    D_Rt;
  logic             D_UseRs;
  logic             D_UseRt;
  logic             D_Wreg;
  logic [AW-1:0]    D_Rd;
  logic [LAT_W-1:0] D_Lat;
  logic             D_Long;
  logic             Flush;
  logic             Stall;
  logic             Issue;
  logic             FwdA;
  logic             FwdB;
  logic             Busy;
  logic [NREG-1:0]  Pending;

  modport master (
    output D_Valid, D_Rs, D_Rt, D_UseRs, D_UseRt, D_Wreg, D_Rd, D_Lat, D_Long, Flush,
    input  Stall, Issue, FwdA, FwdB, Busy, Pending
  );

  modport slave (
    input  D_Valid, D_Rs, D_Rt, D_UseRs, D_UseRt, D_Wreg, D_Rd, D_Lat, D_Long, Flush,
    output Stall, Issue, FwdA, FwdB, Busy, Pending
  );
endinterface

// File: rtl/pipe_sb_entry.sv
// One register's pending-latency counter plus the shadow value needed to undo
// the most recent write to it when that write is flushed.
module pipe_sb_entry
  import pipe_sb_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             restore,
  input  logic [LAT_W-1:0] lat,
  output logic [LAT_W-1:0] rem
);

  logic [LAT_W-1:0] prv;

  // prv holds what rem would have counted down to had the load not happened,
  // so a restore one cycle later steps it once more.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      prv <= '0;
    end else if (restore) begin
      rem <= sat_dec(prv);
    end else if (load) begin
      prv <= sat_dec(rem);
      rem <= lat;
    end else begin
      rem <= sat_dec(rem);
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Decode-stage hazard scoreboard: per-register pending latency, one shared long-latency
// unit, combinational stall/bypass decisions and one-deep flush undo.
module pipe_scoreboard
  import pipe_sb_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int AW      = AW_DEF,
  parameter int LAT_W   = LAT_W_DEF,
  parameter int MAX_LAT = MAX_LAT_DEF
) (
  input  logic     Clk,
  input  logic     Clrn,
  pipe_sb_if.slave sb
);

  logic [LAT_W-1:0] rem [NREG];
  logic [LAT_W-1:0] eff_lat;
  logic [LAT_W-1:0] rem_rs, rem_rt, rem_rd;
  logic [LAT_W-1:0] ucnt, lprv_u;
  logic             lv, llong;
  logic [AW-1:0]    lrd;
  logic             raw_a, raw_b, waw, unit_busy, stall, issue;
  logic [NREG-1:1]  ld_en, rs_en;
  logic [NREG-1:0]  pending;

  // A zero latency behaves as single-cycle; anything past MAX_LAT is clamped.
  always_comb begin
    eff_lat = sb.D_Lat;
    if (sb.D_Lat == '0) eff_lat = LAT_W'(1);
    else if (sb.D_Lat > LAT_W'(MAX_LAT)) eff_lat = LAT_W'(MAX_LAT);
  end

  assign rem[0] = '0;

  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_entry
      assign ld_en[r] = issue & sb.D_Wreg & (sb.D_Rd == AW'(r));
      assign rs_en[r] = sb.Flush & lv & (lrd == AW'(r));
      pipe_sb_entry #(.LAT_W(LAT_W)) u_entry (
        .clk     (Clk),
        .rst_n   (Clrn),
        .load    (ld_en[r]),
        .restore (rs_en[r]),
        .lat     (eff_lat),
        .rem     (rem[r])
      );
    end
  endgenerate

  assign rem_rs = rem[sb.D_Rs];
  assign rem_rt = rem[sb.D_Rt];
  assign rem_rd = rem[sb.D_Rd];

  // Register 0 always reads as zero, so it never creates a hazard.
  assign raw_a     = sb.D_UseRs & (sb.D_Rs != '0) & (rem_rs > LAT_W'(1));
  assign raw_b     = sb.D_UseRt & (sb.D_Rt != '0) & (rem_rt > LAT_W'(1));
  assign waw       = sb.D_Wreg & (sb.D_Rd != '0) & (eff_lat < rem_rd);
  assign unit_busy = sb.D_Long & (ucnt > LAT_W'(1));

  assign stall = sb.D_Valid & (raw_a | raw_b | waw | unit_busy);
  assign issue = sb.D_Valid & ~stall & ~sb.Flush;

  assign sb.Stall = stall;
  assign sb.Issue = issue;
  assign sb.FwdA  = (sb.D_Valid & sb.D_UseRs & (sb.D_Rs != '0) & (rem_rs == LAT_W'(1)))
                    ? FWD_BYP : FWD_REG;
  assign sb.FwdB  = (sb.D_Valid & sb.D_UseRt & (sb.D_Rt != '0) & (rem_rt == LAT_W'(1)))
                    ? FWD_BYP : FWD_REG;
  assign sb.Busy  = (ucnt != '0);

  always_comb begin
    pending = '0;
    for (int i = 1; i < NREG; i++) pending[i] = (rem[i] != '0);
  end
  assign sb.Pending = pending;

  // Shared long unit and the record of last cycle's issue used to undo it on Flush.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      ucnt   <= '0;
      lprv_u <= '0;
      lv     <= 1'b0;
      lrd    <= '0;
      llong  <= 1'b0;
    end else begin
      lv    <= issue & sb.D_Wreg & (sb.D_Rd != '0);
      lrd   <= sb.D_Rd;
      llong <= issue & sb.D_Long;
      if (sb.Flush & llong) begin
        ucnt <= sat_dec(lprv_u);
      end else if (issue & sb.D_Long) begin
        lprv_u <= sat_dec(ucnt);
        ucnt   <= eff_lat;
      end else begin
        ucnt <= sat_dec(ucnt);
      end
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: each step queues the expected
// {Stall,Issue,FwdA,FwdB,Busy,Pending} and checks it mid-cycle.
module tb_pipe_scoreboard;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int LAT_W = 3;

  logic Clk;
  logic Clrn;

  pipe_sb_if #(.NREG(NREG), .AW(AW), .LAT_W(LAT_W)) bus ();

  pipe_scoreboard #(.NREG(NREG), .AW(AW), .LAT_W(LAT_W), .MAX_LAT(7)) dut (
    .Clk  (Clk),
    .Clrn (Clrn),
    .sb   (bus)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int checks = 0;
  int passed = 0;
  int failed = 0;
  logic [36:0] exp_q[$];

  // driver
  task automatic drv(input logic v, input int rs, input int rt, input logic ur,
                     input logic ut, input logic w, input int rd, input int lat,
                     input logic lg, input logic fl);
    bus.D_Valid = v;
    bus.D_Rs    = AW'(rs);
    bus.D_Rt    = AW'(rt);
    bus.D_UseRs = ur;
    bus.D_UseRt = ut;
    bus.D_Wreg  = w;
    bus.D_Rd    = AW'(rd);
    bus.D_Lat   = LAT_W'(lat);
    bus.D_Long  = lg;
    bus.Flush   = fl;
  endtask

  task automatic idle();
    drv(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // scoreboard: push expectation, compare on the falling edge, advance one cycle
  task automatic step(input logic [4:0] outs, input logic [31:0] pend, input string tag);
    logic [36:0] obs;
    logic [36:0] exp;
    exp_q.push_back({outs, pend});
    @(negedge Clk);
    obs = {bus.Stall, bus.Issue, bus.FwdA, bus.FwdB, bus.Busy, bus.Pending};
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got S/I/A/B/Bz=%b pend=%h, want S/I/A/B/Bz=%b pend=%h",
             tag, obs[36:32], obs[31:0], exp[36:32], exp[31:0]);
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  // bit order of outs: Stall Issue FwdA FwdB Busy
  initial begin
    Clrn = 1'b0;
    idle();
    step(5'b00000, 32'h0, "reset_state");
    Clrn = 1'b1;

    // ALU producer of $3, then consumers with Rs==Rt
    drv(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);  step(5'b01000, 32'h0, "alu_issue");
    drv(1, 3, 3, 1, 1, 0, 0, 1, 0, 0);  step(5'b01110, 32'h8, "alu_fwd_both");
    drv(1, 3, 0, 1, 0, 0, 0, 1, 0, 0);  step(5'b01000, 32'h0, "alu_regfile");

    // load producer of $5, consumer on Rt
    drv(1, 0, 0, 0, 0, 1, 5, 2, 0, 0);  step(5'b01000, 32'h0, "load_issue");
    drv(1, 0, 5, 0, 1, 0, 0, 1, 0, 0);  step(5'b10000, 32'h20, "load_stall");
    step(5'b01010, 32'h20, "load_fwd_b");
    idle();                             step(5'b00000, 32'h0, "load_done");

    // divide writing $8, then a second long-unit instruction
    drv(1, 0, 0, 0, 0, 1, 8, 6, 1, 0);  step(5'b01000, 32'h0, "div_issue");
    drv(1, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    for (int i = 0; i < 5; i++) step(5'b10001, 32'h100, "div_struct_stall");
    step(5'b01001, 32'h100, "div_second_issue");
    idle();
    for (int i = 0; i < 3; i++) step(5'b00001, 32'h0, "div_busy_tail");
    step(5'b00000, 32'h0, "div_unit_free");

    // WAW on $4, then writes to $0
    drv(1, 0, 0, 0, 0, 1, 4, 5, 0, 0);  step(5'b01000, 32'h0, "waw_first");
    drv(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(5'b10000, 32'h10, "waw_stall");
    step(5'b01000, 32'h10, "waw_issue");
    idle();                             step(5'b00000, 32'h10, "waw_tail");
    drv(1, 0, 0, 1, 0, 1, 0, 7, 0, 0);  step(5'b01000, 32'h0, "r0_write_long");
    drv(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);  step(5'b01000, 32'h0, "r0_write_short");
    drv(1, 0, 0, 1, 1, 0, 0, 1, 0, 0);  step(5'b01000, 32'h0, "r0_read");

    // flush undoes a write to $6, zero latency treated as one
    drv(1, 0, 0, 0, 0, 1, 6, 3, 0, 0);  step(5'b01000, 32'h0, "flush_first");
    drv(1, 0, 0, 0, 0, 1, 6, 4, 0, 0);  step(5'b01000, 32'h40, "flush_victim");
    drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 1);  step(5'b00000, 32'h40, "flush_cycle");
    drv(1, 6, 0, 1, 0, 0, 0, 1, 0, 0);  step(5'b01100, 32'h40, "flush_restored");
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  step(5'b00000, 32'h0, "flush_no_lv");

    // flush undoes a long-unit issue
    drv(1, 0, 0, 0, 0, 0, 0, 5, 1, 0);  step(5'b01000, 32'h0, "long_issue");
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  step(5'b00001, 32'h0, "long_flush");
    idle();                             step(5'b00000, 32'h0, "long_restored");

    // reset in the middle of activity
    drv(1, 0, 0, 0, 0, 1, 9, 7, 0, 0);  step(5'b01000, 32'h0, "rst_pre_a");
    drv(1, 0, 0, 0, 0, 1, 10, 4, 1, 0); step(5'b01000, 32'h200, "rst_pre_b");
    idle();                             step(5'b00001, 32'h600, "rst_loaded");
    Clrn = 1'b0;                        step(5'b00000, 32'h0, "rst_mid_op");
    Clrn = 1'b1;
    drv(1, 9, 10, 1, 1, 1, 10, 1, 1, 0); step(5'b01000, 32'h0, "rst_first_issue");
    idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
